sram_read_arbiter: RTL and testbench

SRAM_READ_ARBITER -- requirements
Module: sram_read_arbiter

---
 rtl/sram_read_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_read_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sram_read_arbiter.sv
// Purpose: shares the two read ports of a 2R1W SRAM among NUM_REQUESTERS clients, round-robin, up to two grants per cycle.
// Latency: rd_grant is combinational in the request cycle; rd_resp_valid/rd_resp_data follow exactly one cycle later.
// Backpressure: a client that is not granted must hold rd_req/rd_addr; the write port is never stalled.

// Two-read, one-write synchronous SRAM with registered read data.
module sram_2r1w #(
  parameter int    DATA_WIDTH        = 32,
  parameter int    SIZE              = 1024,
  parameter int    ADDR_WIDTH        = $clog2(SIZE),
  parameter string READ_DURING_WRITE = "NEW_DATA"
) (
  input  logic                  clk,
  input  logic                  read0_en,
  input  logic [ADDR_WIDTH-1:0] read0_addr,
  output logic [DATA_WIDTH-1:0] read0_data,
  input  logic                  read1_en,
  input  logic [ADDR_WIDTH-1:0] read1_addr,
  output logic [DATA_WIDTH-1:0] read1_data,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data
);

  // A read colliding with a write to the same word returns the word being written.
  localparam bit NEW_DATA = (READ_DURING_WRITE == "NEW_DATA");

  logic [DATA_WIDTH-1:0] mem [SIZE];

  // Memory array write and registered reads with optional write-through bypass.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
    if (read0_en) begin
      if (NEW_DATA && write_en && (write_addr == read0_addr)) read0_data <= write_data;
      else                                                    read0_data <= mem[read0_addr];
    end
    if (read1_en) begin
      if (NEW_DATA && write_en && (write_addr == read1_addr)) read1_data <= write_data;
      else                                                    read1_data <= mem[read1_addr];
    end
  end

endmodule

module sram_read_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int SIZE           = 1024,
  parameter int NUM_REQUESTERS = 4,
  parameter int ADDR_WIDTH     = $clog2(SIZE)
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [NUM_REQUESTERS-1:0]                  rd_req,
  input  logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_REQUESTERS-1:0]                  rd_grant,
  output logic [NUM_REQUESTERS-1:0]                  rd_resp_valid,
  output logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0]  rd_resp_data,
  input  logic                                       write_en,
  input  logic [ADDR_WIDTH-1:0]                      write_addr,
  input  logic [DATA_WIDTH-1:0]                      write_data
);

  localparam int               PTR_W  = $clog2(NUM_REQUESTERS);
  localparam logic [PTR_W:0]   NREQ_W = (PTR_W+1)'(NUM_REQUESTERS);
  localparam logic [PTR_W-1:0] LAST_C = PTR_W'(NUM_REQUESTERS - 1);

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rr_ptr_nxt;
  logic [PTR_W:0]        cand;
  logic                  p1_vld, p2_vld;
  logic [PTR_W-1:0]      p1_idx, p2_idx;
  logic [PTR_W-1:0]      last_idx;
  logic                  p1_vld_q, p2_vld_q;
  logic [PTR_W-1:0]      p1_idx_q, p2_idx_q;
  logic [DATA_WIDTH-1:0] port1_data, port2_data;

  // Circular scan from rr_ptr: first requester takes port 1, the next takes port 2.
  always_comb begin
    p1_vld = 1'b0;
    p2_vld = 1'b0;
    p1_idx = '0;
    p2_idx = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      cand = {1'b0, rr_ptr} + k[PTR_W:0];
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (reset_n && rd_req[cand[PTR_W-1:0]]) begin
        if (!p1_vld) begin
          p1_vld = 1'b1;
          p1_idx = cand[PTR_W-1:0];
        end else if (!p2_vld) begin
          p2_vld = 1'b1;
          p2_idx = cand[PTR_W-1:0];
        end
      end
    end
  end

  // Grant vector and the pointer value that follows the last client served.
  always_comb begin
    rd_grant = '0;
    if (p1_vld) rd_grant[p1_idx] = 1'b1;
    if (p2_vld) rd_grant[p2_idx] = 1'b1;
    last_idx   = p2_vld ? p2_idx : p1_idx;
    rr_ptr_nxt = (last_idx == LAST_C) ? '0 : last_idx + 1'b1;
  end

  // Round-robin pointer, response valids and the client-to-port mapping of each grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr        <= '0;
      rd_resp_valid <= '0;
      p1_vld_q      <= 1'b0;
      p2_vld_q      <= 1'b0;
      p1_idx_q      <= '0;
      p2_idx_q      <= '0;
    end else begin
      if (p1_vld) rr_ptr <= rr_ptr_nxt;
      rd_resp_valid <= rd_grant;
      p1_vld_q      <= p1_vld;
      p2_vld_q      <= p2_vld;
      p1_idx_q      <= p1_idx;
      p2_idx_q      <= p2_idx;
    end
  end

  // Steer each SRAM read port's data to the client it served last cycle.
  always_comb begin
    rd_resp_data = '0;
    if (p1_vld_q) rd_resp_data[p1_idx_q] = port1_data;
    if (p2_vld_q) rd_resp_data[p2_idx_q] = port2_data;
  end

  sram_2r1w #(
    .DATA_WIDTH        (DATA_WIDTH),
    .SIZE              (SIZE),
    .ADDR_WIDTH        (ADDR_WIDTH),
    .READ_DURING_WRITE ("NEW_DATA")
  ) u_sram (
    .clk        (clk),
    .read0_en   (p1_vld),
    .read0_addr (rd_addr[p1_idx]),
    .read0_data (port1_data),
    .read1_en   (p2_vld),
    .read1_addr (rd_addr[p2_idx]),
    .read1_data (port2_data),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data)
  );

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Purpose: scoreboard bench for sram_read_arbiter (4 clients, 32-bit words, 1024 deep).
// Latency: grants checked in the request cycle, responses checked one cycle later.
// Backpressure: ungranted random requests are held until granted.
module tb_sram_read_arbiter;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [3:0]      rd_req;
  logic [3:0][9:0] rd_addr;
  logic [3:0]      rd_grant;
  logic [3:0]      rd_resp_valid;
  logic [3:0][31:0] rd_resp_data;
  logic            write_en;
  logic [9:0]      write_addr;
  logic [31:0]     write_data;

  sram_read_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_grant      (rd_grant),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_data  (rd_resp_data),
    .write_en      (write_en),
    .write_addr    (write_addr),
    .write_data    (write_data)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          m_ptr   = 0;
  logic [31:0] ref_mem [1024];
  logic [31:0] expq [4][$];
  logic [3:0]  exp_vld = '0;
  logic [3:0]  last_eg = '0;
  int          waitc [4];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference arbitration: walk clients in circular order from ptr, take up to two.
  function automatic logic [3:0] model_grant(input logic [3:0] req, input int ptr, output int last);
    logic [3:0] g = '0;
    int n = 0;
    last = -1;
    for (int k = 0; k < 4; k++) begin
      int c = (ptr + k) % 4;
      if (req[c] && n < 2) begin
        g[c] = 1'b1;
        n++;
        last = c;
      end
    end
    return g;
  endfunction

  task automatic step(input logic [3:0] req, input logic [3:0][9:0] addr,
                      input bit we, input logic [9:0] wa, input logic [31:0] wd,
                      input bit rst, input bit late_rst);
    logic [3:0] eg;
    int         last;
    @(posedge clk);
    #1;
    reset_n    = !rst;
    rd_req     = req;
    rd_addr    = addr;
    write_en   = we;
    write_addr = wa;
    write_data = wd;
    @(negedge clk);
    chk("resp_valid", {28'd0, rd_resp_valid}, {28'd0, exp_vld});
    for (int i = 0; i < 4; i++) begin
      if (exp_vld[i]) begin
        logic [31:0] e = expq[i].pop_front();
        chk($sformatf("resp_data%0d", i), rd_resp_data[i], e);
      end
    end
    last = -1;
    if (rst) eg = '0;
    else     eg = model_grant(req, m_ptr, last);
    chk("grant", {28'd0, rd_grant}, {28'd0, eg});
    for (int i = 0; i < 4; i++) begin
      if (eg[i]) begin
        chk($sformatf("wait%0d", i), 32'(waitc[i] <= 1), 32'd1);
        waitc[i] = 0;
        if (!late_rst)
          expq[i].push_back((we && wa == addr[i]) ? wd : ref_mem[addr[i]]);
      end else if (req[i] && !rst) begin
        waitc[i]++;
      end else begin
        waitc[i] = 0;
      end
    end
    exp_vld = eg;
    last_eg = eg;
    if (rst) m_ptr = 0;
    else if (last >= 0) m_ptr = (last + 1) % 4;
    if (we) ref_mem[wa] = wd;
    if (late_rst) begin
      reset_n = 1'b0;
      exp_vld = '0;
      m_ptr   = 0;
      for (int i = 0; i < 4; i++) waitc[i] = 0;
    end
  endtask

  logic [3:0][9:0] a;
  logic [3:0]      cur_req;
  logic [3:0][9:0] cur_addr;

  initial begin
    reset_n = 1'b0; rd_req = '0; rd_addr = '0;
    write_en = 1'b0; write_addr = '0; write_data = '0;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    a = '0;

    // Reset with all clients requesting: no grant, no response.
    repeat (3) step(4'b1111, a, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0);

    // Preload words 0..15 (word 5 = DEADBEEF) while idle.
    for (int i = 0; i < 16; i++)
      step(4'b0000, a, 1'b1, 10'(i), (i == 5) ? 32'hDEADBEEF : (32'hA5A50000 ^ (32'(i) * 32'h01010101)),
           1'b0, 1'b0);

    // Client 0 reads word 5, then an idle cycle to collect the response.
    a[0] = 10'd5;
    step(4'b0001, a, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
    step(4'b0000, a, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);

    // Reset pulse keeps memory; then all four clients request continuously.
    step(4'b0000, a, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0);
    a[0] = 10'd1; a[1] = 10'd2; a[2] = 10'd3; a[3] = 10'd4;
    repeat (6) step(4'b1111, a, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);

    // Move pointer to 2, then clients 1 and 3 request: client 3 on port 1, client 1 on port 2.
    step(4'b0011, a, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
    a[1] = 10'd7; a[3] = 10'd8;
    step(4'b1010, a, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);

    // Clients 0 and 2 read word 9 while it is written.
    a[0] = 10'd9; a[2] = 10'd9;
    step(4'b0101, a, 1'b1, 10'd9, 32'h12345678, 1'b0, 1'b0);
    step(4'b0000, a, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);

    // Client 2 granted, reset asserted before the next edge: no response, pointer back to 0.
    a[2] = 10'd3;
    step(4'b0100, a, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1);
    step(4'b0000, a, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0);
    step(4'b1111, a, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
    step(4'b0000, a, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);

    // Random traffic on words 0..15 with held requests and random writes.
    cur_req = '0; cur_addr = '0; last_eg = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(cur_req[i] && !last_eg[i])) begin
          cur_req[i]  = ($urandom_range(0, 3) != 0);
          cur_addr[i] = 10'($urandom_range(0, 15));
        end
      end
      step(cur_req, cur_addr, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
           1'b0, 1'b0);
    end
    step(4'b0000, a, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
    step(4'b0000, a, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++)
      chk($sformatf("leftover%0d", i), 32'(expq[i].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
